// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer and the data memory.
//   - RW_type encodings: [1:0] selects byte/half/word and [2] marks unsigned.
//   - sb_entry_t: one buffered store (address, access type, right-aligned data).
//   - same_word(): true when two byte addresses fall in the same 32-bit word.
package store_buffer_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  rw_type;
    logic [31:0] data;
  } sb_entry_t;

  // The hazard check is word-granular on purpose, so access width is ignored.
  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// sb_fifo: circular storage for buffered stores.
// Ports:
//   clk, rst_n   - clock and asynchronous active-low reset
//   push         - write push_entry at wr_ptr this edge (caller guarantees not full)
//   push_entry   - store to enqueue
//   pop          - retire the head this edge (caller guarantees not empty)
//   head         - entry at rd_ptr
//   count        - number of occupied entries (0..DEPTH)
//   entries      - all storage slots, for the hazard compare in the parent
//   occupied     - per-slot flag: slot holds a pending store
// Pointers and count are reset; payload storage is intentionally left unreset.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  sb_entry_t                push_entry,
  input  logic                     pop,
  output sb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output sb_entry_t [DEPTH-1:0]    entries,
  output logic [DEPTH-1:0]         occupied
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count_q;
  sb_entry_t     mem [DEPTH];
  logic [PW-1:0] offs [DEPTH];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // A slot is occupied when its distance from rd_ptr (mod DEPTH) is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      offs[i]     = PW'(i) - rd_ptr;
      occupied[i] = {1'b0, offs[i]} < count_q;
      entries[i]  = mem[i];
    end
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/store_buffer.sv
// store_buffer: buffers stores between the pipeline and a single-port data
// memory, letting loads take the port first unless they hit a pending store.
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   st_valid/st_ready               - store offer/accept handshake
//   st_addr, st_type, st_data       - store payload (data right-aligned)
//   ld_req, ld_addr, ld_type        - load issued this cycle
//   ld_stall                        - load hits a pending store word; hold it
//   mem_W_en, mem_R_en              - data memory write/read enables
//   mem_addr, mem_RW_type, mem_din  - data memory access fields
//   sb_empty, sb_count              - drain status for fence/ecall
// Handshake: a store transfers at a rising edge where st_valid && st_ready.
// st_ready depends only on the current count, so a full buffer refuses a store
// even when the head drains in that same cycle.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [31:0]            st_addr,
  input  logic [2:0]             st_type,
  input  logic [31:0]            st_data,
  input  logic                   ld_req,
  input  logic [31:0]            ld_addr,
  input  logic [2:0]             ld_type,
  output logic                   ld_stall,
  output logic                   mem_W_en,
  output logic                   mem_R_en,
  output logic [31:0]            mem_addr,
  output logic [2:0]             mem_RW_type,
  output logic [31:0]            mem_din,
  output logic                   sb_empty,
  output logic [$clog2(DEPTH):0] sb_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic                  push;
  logic                  drain;
  logic                  rd_go;
  logic                  hit;
  sb_entry_t             push_entry;
  sb_entry_t             head;
  logic [CW-1:0]         count;
  sb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      occupied;

  assign push_entry = '{addr: st_addr, rw_type: st_type, data: st_data};
  assign st_ready   = (count != FULL);
  assign push       = st_valid && st_ready;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (drain),
    .head       (head),
    .count      (count),
    .entries    (entries),
    .occupied   (occupied)
  );

  // Only entries already in storage are compared; a store pushed this cycle
  // is younger than the load and cannot be in 'occupied' yet.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occupied[i] && same_word(entries[i].addr, ld_addr)) hit = 1'b1;
    end
  end

  assign ld_stall = ld_req && hit;

  // A stalled load yields the port, so the drain removes the hazard.
  assign rd_go = ld_req && !ld_stall;
  assign drain = !rd_go && (count != '0);

  assign mem_R_en    = rd_go;
  assign mem_W_en    = drain;
  assign mem_addr    = rd_go ? ld_addr : head.addr;
  assign mem_RW_type = rd_go ? ld_type : head.rw_type;
  assign mem_din     = head.data;

  assign sb_empty = (count == '0);
  assign sb_count = count;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_type;
  logic        ld_req, ld_stall;
  logic [31:0] ld_addr;
  logic [2:0]  ld_type;
  logic        mem_W_en, mem_R_en;
  logic [31:0] mem_addr, mem_din;
  logic [2:0]  mem_RW_type;
  logic        sb_empty;
  logic [$clog2(DEPTH):0] sb_count;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_type(st_type), .st_data(st_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_type(ld_type), .ld_stall(ld_stall),
    .mem_W_en(mem_W_en), .mem_R_en(mem_R_en), .mem_addr(mem_addr),
    .mem_RW_type(mem_RW_type), .mem_din(mem_din),
    .sb_empty(sb_empty), .sb_count(sb_count)
  );

  // ---------------- scoreboard ----------------
  // Pending stores in acceptance order, packed {addr[66:35], type[34:32], data[31:0]}.
  logic [66:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] type_tab [5] = '{LS_B, LS_H, LS_W, LS_BU, LS_HU};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  // ---------------- driver: one cycle, checked against the model ----------------
  task automatic step(input logic sv, input logic [31:0] sa, input logic [2:0] stt,
                      input logic [31:0] sd, input logic lr, input logic [31:0] la,
                      input logic [2:0] lt);
    logic hz, rd, wr, acc;
    @(negedge clk);
    st_valid = sv; st_addr = sa; st_type = stt; st_data = sd;
    ld_req = lr; ld_addr = la; ld_type = lt;
    #1;
    hz = 1'b0;
    foreach (exp_q[i]) if (exp_q[i][66:37] == la[31:2]) hz = 1'b1;
    hz  = hz && lr;
    rd  = lr && !hz;
    wr  = !rd && (exp_q.size() != 0);
    acc = sv && (exp_q.size() < DEPTH);
    check("st_ready", st_ready, exp_q.size() < DEPTH);
    check("ld_stall", ld_stall, hz);
    check("mem_R_en", mem_R_en, rd);
    check("mem_W_en", mem_W_en, wr);
    check("sb_count", 32'(sb_count), exp_q.size());
    check("sb_empty", sb_empty, exp_q.size() == 0);
    if (rd) begin
      check("rd_addr", mem_addr, la);
      check("rd_type", 32'(mem_RW_type), 32'(lt));
    end
    if (wr) begin
      check("wr_addr", mem_addr, exp_q[0][66:35]);
      check("wr_type", 32'(mem_RW_type), 32'(exp_q[0][34:32]));
      check("wr_din",  mem_din,  exp_q[0][31:0]);
    end
    @(posedge clk);
    if (wr)  void'(exp_q.pop_front());
    if (acc) exp_q.push_back({sa, stt, sd});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, LS_W, 32'h0, 1'b0, 32'h0, LS_W);
  endtask

  task automatic reset_checks();
    check("rst_count", 32'(sb_count), 32'd0);
    check("rst_empty", sb_empty, 1'b1);
    check("rst_ready", st_ready, 1'b1);
    check("rst_W_en",  mem_W_en, 1'b0);
    check("rst_R_en",  mem_R_en, 1'b0);
    check("rst_stall", ld_stall, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    st_valid = 1'b0; st_addr = '0; st_type = LS_W; st_data = '0;
    ld_req = 1'b0; ld_addr = '0; ld_type = LS_W;
    #1;
    reset_checks();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word store retires one cycle later, then the buffer is empty.
    step(1'b1, 32'h40, LS_W, 32'h11223344, 1'b0, 32'h0, LS_W);
    idle(2);

    // Fill with loads holding the port; the fifth store waits for space.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h200 + 32'(i * 4), LS_W, 32'hA000 + 32'(i), 1'b1, 32'h100, LS_W);
    for (int i = 0; i < 2; i++)
      step(1'b1, 32'h300, LS_H, 32'hBEEF, 1'b1, 32'h100, LS_W);
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h300, LS_H, 32'hBEEF, 1'b0, 32'h0, LS_W);
    idle(6);

    // Byte store then word load to the same word: stall, drain, then read.
    step(1'b1, 32'h41, LS_B, 32'hAB, 1'b0, 32'h0, LS_W);
    step(1'b0, 32'h0, LS_W, 32'h0, 1'b1, 32'h40, LS_W);
    step(1'b0, 32'h0, LS_W, 32'h0, 1'b1, 32'h40, LS_W);

    // Load to a neighbouring word is not a hazard and blocks the drain.
    step(1'b1, 32'h84, LS_W, 32'h5555AAAA, 1'b0, 32'h0, LS_W);
    step(1'b0, 32'h0, LS_W, 32'h0, 1'b1, 32'h80, LS_W);
    step(1'b0, 32'h0, LS_W, 32'h0, 1'b1, 32'h80, LS_HU);
    idle(2);

    // Reach count=2, then push and drain together across pointer wrap.
    step(1'b1, 32'h500, LS_W, 32'h1, 1'b1, 32'h900, LS_W);
    step(1'b1, 32'h504, LS_W, 32'h2, 1'b1, 32'h900, LS_W);
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'h600 + 32'(i * 4), LS_W, 32'h10 + 32'(i), 1'b0, 32'h0, LS_W);
    idle(4);

    // Randomized traffic over a small address window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) == 1,
           32'h40 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
           type_tab[$urandom_range(0, 4)], $urandom,
           $urandom_range(0, 2) != 0,
           32'h40 + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3)),
           type_tab[$urandom_range(0, 4)]);
    end
    idle(6);

    // Reset with three stores pending: all discarded, nothing written.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h700 + 32'(i * 4), LS_W, 32'h77 + 32'(i), 1'b1, 32'hF00, LS_W);
    @(negedge clk);
    st_valid = 1'b0; ld_req = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    reset_checks();
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_W_en", mem_W_en, 1'b0);
    rst_n = 1'b1;
    idle(3);

    // Traffic after reset still works.
    step(1'b1, 32'h44, LS_HU, 32'hCAFE, 1'b0, 32'h0, LS_W);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
